// File: rtl/ac_interval_coder.sv
// rtl/ac_interval_coder.sv - binary arithmetic-coder interval update and E1/E2/E3 renormalisation (option: AC_BIT_COUNT_EN)
module ac_interval_coder #(
    parameter int PEND_W = 16
) (
    input  logic        clk,
    input  logic        srst_n,
    input  logic        fifo_empty_in,
    output logic        read_en,
    input  logic        valid_in,
    input  logic [15:0] upper_bound_in,
    input  logic [15:0] lower_bound_in,
    input  logic        flush_in,
    output logic        bit_out,
    output logic        bit_valid,
    input  logic        bit_ready,
    output logic        busy,
    output logic        done,
    output logic        err_bounds,
    output logic        err_pend_ovf
`ifdef AC_BIT_COUNT_EN
    ,
    output logic [31:0] bit_count
`endif
);

    localparam logic [15:0]       HALF     = 16'h8000;
    localparam logic [15:0]       QTR      = 16'h4000;
    localparam logic [15:0]       TQTR     = 16'hC000;
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_UPDATE, S_RENORM, S_EMIT, S_PEND, S_FLUSH, S_DONE
    } state_t;

    state_t             r_state, w_next;
    logic [15:0]        r_low, r_high;
    logic [PEND_W-1:0]  r_pend;
    logic [16:0]        r_q_hi, r_q_lo;
    logic               r_flush, r_flushing, r_bit, r_read_en;
    logic               r_err_bounds, r_err_pend_ovf;
`ifdef AC_BIT_COUNT_EN
    logic [31:0]        r_bit_count;
`endif

    logic [16:0] w_range, w_upper_p1, w_q_hi, w_q_lo, w_sum_hi, w_sum_lo;
    logic        w_accept, w_e1, w_e2, w_e3, w_bad;

    // Scaled bounds: (range*(upper+1))>>16 and (range*lower)>>16 in full 34-bit precision
    assign w_range    = {1'b0, r_high} - {1'b0, r_low} + 17'd1;
    assign w_upper_p1 = {1'b0, upper_bound_in} + 17'd1;
    assign w_q_hi     = 17'((34'(w_range) * 34'(w_upper_p1)) >> 16);
    assign w_q_lo     = 17'((34'(w_range) * 34'({1'b0, lower_bound_in})) >> 16);
    assign w_sum_hi   = {1'b0, r_low} + r_q_hi - 17'd1;
    assign w_sum_lo   = {1'b0, r_low} + r_q_lo;

    assign w_bad    = lower_bound_in > upper_bound_in;
    assign w_accept = bit_valid & bit_ready;
    assign w_e1     = r_high < HALF;
    assign w_e2     = r_low >= HALF;
    assign w_e3     = (r_low >= QTR) && (r_high < TQTR);

    assign read_en      = r_read_en;
    assign bit_valid    = (r_state == S_EMIT) || (r_state == S_PEND);
    assign bit_out      = bit_valid & ((r_state == S_PEND) ? ~r_bit : r_bit);
    assign busy         = r_state != S_IDLE;
    assign done         = r_state == S_DONE;
    assign err_bounds   = r_err_bounds;
    assign err_pend_ovf = r_err_pend_ovf;
`ifdef AC_BIT_COUNT_EN
    assign bit_count    = r_bit_count;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!srst_n) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // Next-state decode; symbols take priority over a pending flush
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (!fifo_empty_in) w_next = S_WAIT;
                      else if (r_flush)   w_next = S_FLUSH;
            S_WAIT:   if (valid_in) w_next = w_bad ? S_IDLE : S_UPDATE;
            S_UPDATE: w_next = S_RENORM;
            S_RENORM: if (w_e1 || w_e2) w_next = S_EMIT;
                      else if (!w_e3)   w_next = S_IDLE;
            S_EMIT:   if (w_accept) begin
                          if (r_pend != '0)    w_next = S_PEND;
                          else if (r_flushing) w_next = S_DONE;
                          else                 w_next = S_RENORM;
                      end
            S_PEND:   if (w_accept && r_pend == PEND_ONE)
                          w_next = r_flushing ? S_DONE : S_RENORM;
            S_FLUSH:  w_next = S_EMIT;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Interval, pending counter, flush latch and sticky error datapath
    always_ff @(posedge clk) begin
        if (!srst_n) begin
            r_low          <= 16'h0000;
            r_high         <= 16'hFFFF;
            r_pend         <= '0;
            r_q_hi         <= '0;
            r_q_lo         <= '0;
            r_flush        <= 1'b0;
            r_flushing     <= 1'b0;
            r_bit          <= 1'b0;
            r_read_en      <= 1'b0;
            r_err_bounds   <= 1'b0;
            r_err_pend_ovf <= 1'b0;
        end else begin
            r_read_en <= (r_state == S_IDLE) && !fifo_empty_in;
            // A new flush request outranks clearing, so a request arriving on entry is kept
            if (flush_in)
                r_flush <= 1'b1;
            else if (r_state == S_IDLE && fifo_empty_in)
                r_flush <= 1'b0;
            case (r_state)
                S_WAIT: if (valid_in) begin
                    if (w_bad) r_err_bounds <= 1'b1;
                    r_q_hi <= w_q_hi;
                    r_q_lo <= w_q_lo;
                end
                S_UPDATE: begin
                    r_high <= w_sum_hi[15:0];
                    r_low  <= w_sum_lo[15:0];
                end
                S_RENORM: begin
                    if (w_e1) begin
                        r_bit <= 1'b0;
                    end else if (w_e2) begin
                        r_bit  <= 1'b1;
                        r_low  <= {1'b0, r_low[14:0]};
                        r_high <= {1'b0, r_high[14:0]};
                    end else if (w_e3) begin
                        if (r_pend == PEND_MAX) r_err_pend_ovf <= 1'b1;
                        else                    r_pend <= r_pend + PEND_ONE;
                        // Subtract QTR then shift: low lies in [QTR,HALF), high in [QTR,3QTR)
                        r_low  <= {1'b0, r_low[13:0], 1'b0};
                        r_high <= {r_high[15], r_high[13:0], 1'b1};
                    end
                end
                S_EMIT: if (w_accept && r_pend == '0) begin
                    r_low  <= {r_low[14:0], 1'b0};
                    r_high <= {r_high[14:0], 1'b1};
                end
                S_PEND: if (w_accept) begin
                    r_pend <= r_pend - PEND_ONE;
                    if (r_pend == PEND_ONE) begin
                        r_low  <= {r_low[14:0], 1'b0};
                        r_high <= {r_high[14:0], 1'b1};
                    end
                end
                S_FLUSH: begin
                    if (r_pend == PEND_MAX) r_err_pend_ovf <= 1'b1;
                    else                    r_pend <= r_pend + PEND_ONE;
                    r_bit      <= r_low >= QTR;
                    r_flushing <= 1'b1;
                end
                S_DONE: begin
                    r_low      <= 16'h0000;
                    r_high     <= 16'hFFFF;
                    r_pend     <= '0;
                    r_flushing <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef AC_BIT_COUNT_EN
    // Accepted-bit counter, restarted at the end of each stream
    always_ff @(posedge clk) begin
        if (!srst_n || r_state == S_DONE) r_bit_count <= '0;
        else if (w_accept)                r_bit_count <= r_bit_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_ac_interval_coder.sv
// tb/tb_ac_interval_coder.sv - scoreboard testbench for ac_interval_coder
module tb_ac_interval_coder;

    logic        clk = 1'b0;
    logic        srst_n = 1'b0;
    logic        fifo_empty_in = 1'b1;
    logic        read_en;
    logic        valid_in = 1'b0;
    logic [15:0] upper_bound_in = '0;
    logic [15:0] lower_bound_in = '0;
    logic        flush_in = 1'b0;
    logic        bit_out, bit_valid, busy, done, err_bounds, err_pend_ovf;
    logic        bit_ready = 1'b1;
`ifdef AC_BIT_COUNT_EN
    logic [31:0] bit_count;
`endif

    int checks = 0;
    int errors = 0;
    int bits_seen = 0;
    int done_seen = 0;
    int ready_mode = 0;
    bit          exp_q[$];
    logic [31:0] fifo_q[$];

    ac_interval_coder #(.PEND_W(16)) dut (
        .clk(clk), .srst_n(srst_n), .fifo_empty_in(fifo_empty_in), .read_en(read_en),
        .valid_in(valid_in), .upper_bound_in(upper_bound_in), .lower_bound_in(lower_bound_in),
        .flush_in(flush_in), .bit_out(bit_out), .bit_valid(bit_valid), .bit_ready(bit_ready),
        .busy(busy), .done(done), .err_bounds(err_bounds), .err_pend_ovf(err_pend_ovf)
`ifdef AC_BIT_COUNT_EN
        , .bit_count(bit_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // FIFO read side: word appears one cycle after read_en, qualified by a one-cycle valid
    initial begin
        logic re;
        forever begin
            @(negedge clk);
            re = read_en;
            @(posedge clk);
            #1;
            valid_in = 1'b0;
            if (re && fifo_q.size() > 0) begin
                {upper_bound_in, lower_bound_in} = fifo_q.pop_front();
                valid_in = 1'b1;
            end
            fifo_empty_in = (fifo_q.size() == 0);
        end
    end

    // Downstream ready pattern
    initial begin
        int cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bit_ready = 1'b1;
                1:       bit_ready = (cyc % 3 == 0);
                default: bit_ready = 1'b0;
            endcase
            cyc++;
        end
    end

    // Monitor: pops expected bits on each handshake and checks stall stability
    initial begin
        bit prev_stall = 1'b0;
        bit prev_bit = 1'b0;
        forever begin
            @(negedge clk);
            if (!srst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (done) done_seen++;
                if (bit_valid) begin
                    if (prev_stall) chk("stall_stable", int'(bit_out), int'(prev_bit));
                    if (bit_ready) begin
                        bits_seen++;
                        if (exp_q.size() == 0) chk("unexpected_bit", 1, 0);
                        else chk("bit", int'(bit_out), int'(exp_q.pop_front()));
                    end
                    prev_stall = !bit_ready;
                    prev_bit   = bit_out;
                end else begin
                    prev_stall = 1'b0;
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        srst_n = 1'b0;
        exp_q.delete();
        fifo_q.delete();
        repeat (2) @(posedge clk);
        #1;
        srst_n = 1'b1;
    endtask

    task automatic push_sym(input logic [15:0] up, input logic [15:0] lo);
        fifo_q.push_back({up, lo});
        fifo_empty_in = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int quiet = 0;
        int n = 0;
        while (quiet < 4 && n < 2000) begin
            @(negedge clk);
            n++;
            if (!busy && fifo_q.size() == 0 && !valid_in) quiet++;
            else quiet = 0;
        end
        if (quiet < 4) chk({name, "_timeout"}, 1, 0);
    endtask

    task automatic check_interval(input string name, input int lo, input int hi);
        chk({name, "_low"}, int'(dut.r_low), lo);
        chk({name, "_high"}, int'(dut.r_high), hi);
    endtask

    initial begin
        int b0, d0, n;
        do_reset();
        @(negedge clk);
        chk("rst_read_en", int'(read_en), 0);
        chk("rst_bit_valid", int'(bit_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_errs", int'({err_bounds, err_pend_ovf}), 0);

        // 1: lower half -> single 0
        b0 = bits_seen;
        exp_q.push_back(1'b0);
        push_sym(16'h7FFF, 16'h0000);
        wait_idle("t1");
        chk("t1_nbits", bits_seen - b0, 1);
        check_interval("t1", 'h0000, 'hFFFF);

        // 2: upper half -> single 1
        do_reset();
        b0 = bits_seen;
        exp_q.push_back(1'b1);
        push_sym(16'hFFFF, 16'h8000);
        wait_idle("t2");
        chk("t2_nbits", bits_seen - b0, 1);
        check_interval("t2", 'h0000, 'hFFFF);

        // 3: middle half defers one bit, resolved by next symbol
        do_reset();
        b0 = bits_seen;
        push_sym(16'hBFFF, 16'h4000);
        wait_idle("t3a");
        chk("t3_nbits_a", bits_seen - b0, 0);
        chk("t3_pend", int'(dut.r_pend), 1);
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        push_sym(16'h7FFF, 16'h0000);
        wait_idle("t3b");
        chk("t3_nbits_b", bits_seen - b0, 2);
        chk("t3_pend_end", int'(dut.r_pend), 0);

        // 4: flush on a fresh interval -> 0,1 then done
        do_reset();
        b0 = bits_seen;
        d0 = done_seen;
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        @(posedge clk);
        #1;
        flush_in = 1'b1;
        @(posedge clk);
        #1;
        flush_in = 1'b0;
        wait_idle("t4");
        chk("t4_nbits", bits_seen - b0, 2);
        chk("t4_done", done_seen - d0, 1);
        chk("t4_busy", int'(busy), 0);

        // 5: test 3 under back-pressure
        do_reset();
        ready_mode = 1;
        b0 = bits_seen;
        push_sym(16'hBFFF, 16'h4000);
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        push_sym(16'h7FFF, 16'h0000);
        wait_idle("t5");
        chk("t5_nbits", bits_seen - b0, 2);
        chk("t5_left", exp_q.size(), 0);
        ready_mode = 0;

        // 6: inverted bounds are dropped, then reset while a bit is stalled
        do_reset();
        b0 = bits_seen;
        push_sym(16'h1000, 16'h2000);
        wait_idle("t6a");
        chk("t6_err", int'(err_bounds), 1);
        chk("t6_nbits", bits_seen - b0, 0);
        check_interval("t6", 'h0000, 'hFFFF);
        ready_mode = 2;
        push_sym(16'h7FFF, 16'h0000);
        n = 0;
        while (!bit_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t6_emit_reached", int'(bit_valid), 1);
        @(posedge clk);
        #1;
        srst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("t6_rst_bit_valid", int'(bit_valid), 0);
        chk("t6_rst_bit_out", int'(bit_out), 0);
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_done", int'(done), 0);
        chk("t6_rst_read_en", int'(read_en), 0);
        chk("t6_rst_errs", int'({err_bounds, err_pend_ovf}), 0);
        exp_q.delete();
        fifo_q.delete();
        ready_mode = 0;
        #1;
        srst_n = 1'b1;
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
